// File: rtl/useq_pkg.sv
// Shared constants and next-state encodings for the microsequencer.
// The optional return stack is enabled with the USEQ_STACK_EN macro.
package useq_pkg;

    localparam int unsigned UADDR_W     = 7;
    localparam int unsigned WCNT_W      = 8;
    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned SP_W        = 3;

    typedef enum logic [2:0] {
        NS_INC   = 3'b000,
        NS_JMP   = 3'b001,
        NS_DISP  = 3'b010,
        NS_CBR   = 3'b011,
        NS_WAIT  = 3'b100,
        NS_FETCH = 3'b101,
        NS_CALL  = 3'b110,
        NS_RET   = 3'b111
    } ns_sel_e;

    // Sequential successor; wraps at the top of the microstore.
    function automatic logic [UADDR_W-1:0] uaddr_inc(input logic [UADDR_W-1:0] a);
        return a + UADDR_W'(1);
    endfunction

endpackage

// File: rtl/useq_next_addr.sv
// Combinational successor-address selection for the microsequencer.
// Stack ports exist only when USEQ_STACK_EN is defined.
module useq_next_addr
    import useq_pkg::*;
#(
    parameter logic [UADDR_W-1:0] FETCH_ADDR = 7'd0,
    parameter logic [UADDR_W-1:0] ABORT_ADDR = 7'd127,
    parameter int unsigned        TIMEOUT    = 255
) (
    input  logic [2:0]         i_ns_sel,
    input  logic [UADDR_W-1:0] i_cr_addr,
    input  logic               i_inv,
    input  logic [1:0]         i_cond_sel,
    input  logic [3:0]         i_cond,
    input  logic [UADDR_W-1:0] i_dispatch_addr,
    input  logic               i_mfc,
    input  logic [UADDR_W-1:0] i_upc,
    input  logic [WCNT_W-1:0]  i_wait_cnt,
`ifdef USEQ_STACK_EN
    input  logic [UADDR_W-1:0] i_stk_top,
    input  logic               i_stk_empty,
    input  logic               i_stk_full,
    output logic               o_push_c,
    output logic               o_pop_c,
    output logic               o_stk_err_c,
`endif
    output logic [UADDR_W-1:0] o_next_upc_c,
    output logic               o_wait_inc_c,
    output logic               o_timeout_c
);

    logic [UADDR_W-1:0] w_inc;
    logic               w_cond_hit;

    assign w_inc      = uaddr_inc(i_upc);
    assign w_cond_hit = i_cond[i_cond_sel] ^ i_inv;

    always_comb begin
        o_next_upc_c = w_inc;
        o_wait_inc_c = 1'b0;
        o_timeout_c  = 1'b0;
`ifdef USEQ_STACK_EN
        o_push_c     = 1'b0;
        o_pop_c      = 1'b0;
        o_stk_err_c  = 1'b0;
`endif
        case (ns_sel_e'(i_ns_sel))
            NS_INC:   o_next_upc_c = w_inc;
            NS_JMP:   o_next_upc_c = i_cr_addr;
            NS_DISP:  o_next_upc_c = i_dispatch_addr;
            NS_CBR:   o_next_upc_c = w_cond_hit ? i_cr_addr : w_inc;
            // Completion beats timeout when both happen in the same cycle.
            NS_WAIT: begin
                if (i_mfc) begin
                    o_next_upc_c = i_cr_addr;
                end else if (i_wait_cnt == WCNT_W'(TIMEOUT)) begin
                    o_next_upc_c = ABORT_ADDR;
                    o_timeout_c  = 1'b1;
                end else begin
                    o_next_upc_c = i_upc;
                    o_wait_inc_c = 1'b1;
                end
            end
            NS_FETCH: o_next_upc_c = FETCH_ADDR;
`ifdef USEQ_STACK_EN
            NS_CALL: begin
                o_next_upc_c = i_cr_addr;
                o_push_c     = !i_stk_full;
                o_stk_err_c  = i_stk_full;
            end
            NS_RET: begin
                o_next_upc_c = i_stk_empty ? FETCH_ADDR : i_stk_top;
                o_pop_c      = !i_stk_empty;
                o_stk_err_c  = i_stk_empty;
            end
`else
            NS_CALL:  o_next_upc_c = i_cr_addr;
            NS_RET:   o_next_upc_c = FETCH_ADDR;
`endif
            default:  o_next_upc_c = w_inc;
        endcase
    end

endmodule

// File: rtl/useq_ctrl.sv
// Microprogram sequencer: upc register, WAIT timeout counter, event pulses and
// an optional 4-deep return stack (USEQ_STACK_EN).
module useq_ctrl
    import useq_pkg::*;
#(
    parameter logic [UADDR_W-1:0] FETCH_ADDR = 7'd0,
    parameter logic [UADDR_W-1:0] ABORT_ADDR = 7'd127,
    parameter int unsigned        TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         ns_sel,
    input  logic [UADDR_W-1:0] cr_addr,
    input  logic               inv,
    input  logic [1:0]         cond_sel,
    input  logic [3:0]         cond,
    input  logic [UADDR_W-1:0] dispatch_addr,
    input  logic               mfc,
    input  logic               stall,
    output logic [UADDR_W-1:0] upc,
    output logic               wait_active,
    output logic               mem_timeout,
    output logic               stack_err
);

    logic [UADDR_W-1:0] r_upc;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic               r_mem_timeout;
    logic [UADDR_W-1:0] w_next_upc;
    logic               w_wait_inc;
    logic               w_timeout;

`ifdef USEQ_STACK_EN
    logic [UADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]    r_sp;
    logic               r_stack_err;
    logic               w_push;
    logic               w_pop;
    logic               w_stk_err;
    logic               w_stk_empty;
    logic               w_stk_full;
    logic [UADDR_W-1:0] w_stk_top;
    logic [UADDR_W-1:0] w_inc;

    assign w_inc       = uaddr_inc(r_upc);
    assign w_stk_empty = (r_sp == '0);
    assign w_stk_full  = (r_sp == SP_W'(STACK_DEPTH));
    assign w_stk_top   = r_stack[2'(r_sp - SP_W'(1))];
`endif

    useq_next_addr #(
        .FETCH_ADDR (FETCH_ADDR),
        .ABORT_ADDR (ABORT_ADDR),
        .TIMEOUT    (TIMEOUT)
    ) u_next_addr (
        .i_ns_sel        (ns_sel),
        .i_cr_addr       (cr_addr),
        .i_inv           (inv),
        .i_cond_sel      (cond_sel),
        .i_cond          (cond),
        .i_dispatch_addr (dispatch_addr),
        .i_mfc           (mfc),
        .i_upc           (r_upc),
        .i_wait_cnt      (r_wait_cnt),
`ifdef USEQ_STACK_EN
        .i_stk_top       (w_stk_top),
        .i_stk_empty     (w_stk_empty),
        .i_stk_full      (w_stk_full),
        .o_push_c        (w_push),
        .o_pop_c         (w_pop),
        .o_stk_err_c     (w_stk_err),
`endif
        .o_next_upc_c    (w_next_upc),
        .o_wait_inc_c    (w_wait_inc),
        .o_timeout_c     (w_timeout)
    );

    // Stall freezes all state; pulses drop so each event is reported once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_upc         <= FETCH_ADDR;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
`ifdef USEQ_STACK_EN
            r_sp          <= '0;
            r_stack_err   <= 1'b0;
`endif
        end else if (stall) begin
            r_mem_timeout <= 1'b0;
`ifdef USEQ_STACK_EN
            r_stack_err   <= 1'b0;
`endif
        end else begin
            r_upc         <= w_next_upc;
            r_wait_cnt    <= w_wait_inc ? r_wait_cnt + WCNT_W'(1) : '0;
            r_mem_timeout <= w_timeout;
`ifdef USEQ_STACK_EN
            r_stack_err   <= w_stk_err;
            if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - SP_W'(1);
            end
`endif
        end
    end

`ifdef USEQ_STACK_EN
    // Return-address storage needs no reset; the pointer defines validity.
    always_ff @(posedge clk) begin
        if (rst_n && !stall && w_push) begin
            r_stack[r_sp[1:0]] <= w_inc;
        end
    end

    assign stack_err = r_stack_err;
`else
    assign stack_err = 1'b0;
`endif

    assign upc         = r_upc;
    assign wait_active = (ns_sel == NS_WAIT);
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_useq_ctrl.sv
// Self-checking bench for useq_ctrl: directed vector table, corner-case
// sequences and randomized stimulus against a queue-based reference model.
module tb_useq_ctrl;
    import useq_pkg::*;

    localparam int unsigned TMO   = 4;
    localparam int          FETCH = 0;
    localparam int          ABORT = 127;

    typedef struct {
        logic [2:0] ns;
        logic [6:0] cr;
        logic       inv;
        logic [1:0] cs;
        logic [3:0] cnd;
        logic [6:0] disp;
        logic       mfc;
        logic       stall;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] eu;
        logic       eto;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ns_sel;
    logic [6:0] cr_addr;
    logic       inv;
    logic [1:0] cond_sel;
    logic [3:0] cond;
    logic [6:0] dispatch_addr;
    logic       mfc;
    logic       stall;
    logic [6:0] upc;
    logic       wait_active;
    logic       mem_timeout;
    logic       stack_err;

    int n_tests = 0;
    int n_fail  = 0;

    int m_upc;
    int m_cnt;
    int m_stk[$];

    vec_t tbl[$];

    always #5 clk = ~clk;

    useq_ctrl #(
        .FETCH_ADDR (7'd0),
        .ABORT_ADDR (7'd127),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ns_sel        (ns_sel),
        .cr_addr       (cr_addr),
        .inv           (inv),
        .cond_sel      (cond_sel),
        .cond          (cond),
        .dispatch_addr (dispatch_addr),
        .mfc           (mfc),
        .stall         (stall),
        .upc           (upc),
        .wait_active   (wait_active),
        .mem_timeout   (mem_timeout),
        .stack_err     (stack_err)
    );

    function automatic in_t mk(input logic [2:0] ns, input logic [6:0] cr,
                               input logic [6:0] disp, input logic m, input logic st);
        in_t x;
        x.ns = ns; x.cr = cr; x.inv = 1'b0; x.cs = 2'd0; x.cnd = 4'd0;
        x.disp = disp; x.mfc = m; x.stall = st;
        return x;
    endfunction

    function automatic in_t mk_cbr(input logic [6:0] cr, input logic iv,
                                   input logic [1:0] cs, input logic [3:0] cnd);
        in_t x;
        x = mk(3'b011, cr, 7'd0, 1'b0, 1'b0);
        x.inv = iv; x.cs = cs; x.cnd = cnd;
        return x;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t x);
        ns_sel = x.ns; cr_addr = x.cr; inv = x.inv; cond_sel = x.cs;
        cond = x.cnd; dispatch_addr = x.disp; mfc = x.mfc; stall = x.stall;
    endtask

    // Reference model: successor rules applied directly to integer state.
    task automatic model_step(input in_t x, output int nu, output bit to, output bit se);
        int inc;
        bit hit;
        nu = m_upc; to = 1'b0; se = 1'b0;
        if (x.stall) return;
        inc = (m_upc + 1) % 128;
        hit = x.cnd[x.cs] ^ x.inv;
        case (x.ns)
            3'd0: nu = inc;
            3'd1: nu = int'(x.cr);
            3'd2: nu = int'(x.disp);
            3'd3: nu = hit ? int'(x.cr) : inc;
            3'd4: begin
                if (x.mfc) nu = int'(x.cr);
                else if (m_cnt == int'(TMO)) begin nu = ABORT; to = 1'b1; end
                else nu = m_upc;
            end
            3'd5: nu = FETCH;
`ifdef USEQ_STACK_EN
            3'd6: begin
                if (m_stk.size() < 4) m_stk.push_back(inc);
                else se = 1'b1;
                nu = int'(x.cr);
            end
            default: begin
                if (m_stk.size() == 0) begin nu = FETCH; se = 1'b1; end
                else nu = m_stk.pop_back();
            end
`else
            3'd6: nu = int'(x.cr);
            default: nu = FETCH;
`endif
        endcase
        if (x.ns == 3'd4 && !x.mfc && !to) m_cnt++;
        else m_cnt = 0;
        m_upc = nu;
    endtask

    // One clock: check wait_active before the edge, then model vs DUT after it.
    task automatic cycle(input in_t x);
        int nu;
        bit to, se;
        drive(x);
        #1;
        chk("wait_active", int'(wait_active), int'(x.ns == 3'd4));
        model_step(x, nu, to, se);
        @(posedge clk);
        #1;
        chk("model_upc", int'(upc), nu);
        chk("model_mem_timeout", int'(mem_timeout), int'(to));
        chk("model_stack_err", int'(stack_err), int'(se));
    endtask

    task automatic do_reset(input in_t x);
        drive(x);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_upc", int'(upc), FETCH);
        chk("reset_mem_timeout", int'(mem_timeout), 0);
        chk("reset_stack_err", int'(stack_err), 0);
        m_upc = FETCH; m_cnt = 0; m_stk.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_holds(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(mk(3'b100, 7'd10, 7'd0, 1'b0, 1'b0));
            chk("wait_hold_upc", int'(upc), 9);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int er[5];
        in_t x;

        tbl.push_back('{mk(3'b000, 7'd0,  7'd0,  1'b0, 1'b0), 7'd1,   1'b0});
        tbl.push_back('{mk(3'b001, 7'd5,  7'd0,  1'b0, 1'b0), 7'd5,   1'b0});
        tbl.push_back('{mk_cbr(7'd40, 1'b0, 2'd2, 4'b0100),   7'd40,  1'b0});
        tbl.push_back('{mk(3'b001, 7'd5,  7'd0,  1'b0, 1'b0), 7'd5,   1'b0});
        tbl.push_back('{mk_cbr(7'd40, 1'b1, 2'd2, 4'b0100),   7'd6,   1'b0});
        tbl.push_back('{mk(3'b010, 7'd3,  7'd77, 1'b0, 1'b0), 7'd77,  1'b0});
        tbl.push_back('{mk(3'b101, 7'd3,  7'd0,  1'b0, 1'b0), 7'd0,   1'b0});
        tbl.push_back('{mk(3'b001, 7'd9,  7'd0,  1'b0, 1'b0), 7'd9,   1'b0});
        tbl.push_back('{mk(3'b100, 7'd10, 7'd0,  1'b0, 1'b0), 7'd9,   1'b0});
        tbl.push_back('{mk(3'b100, 7'd10, 7'd0,  1'b0, 1'b0), 7'd9,   1'b0});
        tbl.push_back('{mk(3'b100, 7'd10, 7'd0,  1'b0, 1'b0), 7'd9,   1'b0});
        tbl.push_back('{mk(3'b100, 7'd10, 7'd0,  1'b1, 1'b0), 7'd10,  1'b0});
        tbl.push_back('{mk(3'b100, 7'd20, 7'd0,  1'b1, 1'b1), 7'd10,  1'b0});
        tbl.push_back('{mk(3'b100, 7'd20, 7'd0,  1'b1, 1'b1), 7'd10,  1'b0});
        tbl.push_back('{mk(3'b100, 7'd20, 7'd0,  1'b1, 1'b1), 7'd10,  1'b0});
        tbl.push_back('{mk(3'b100, 7'd20, 7'd0,  1'b1, 1'b0), 7'd20,  1'b0});
        tbl.push_back('{mk(3'b001, 7'd127,7'd0,  1'b0, 1'b0), 7'd127, 1'b0});
        tbl.push_back('{mk(3'b000, 7'd0,  7'd0,  1'b0, 1'b0), 7'd0,   1'b0});
        tbl.push_back('{mk(3'b000, 7'd0,  7'd0,  1'b0, 1'b1), 7'd0,   1'b0});

        rst_n = 1'b0;
        do_reset(mk(3'b000, 7'd0, 7'd0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            cycle(tbl[i].in);
            chk($sformatf("tbl%0d_upc", i), int'(upc), int'(tbl[i].eu));
            chk($sformatf("tbl%0d_mem_timeout", i), int'(mem_timeout), int'(tbl[i].eto));
        end

        // Sequential walk with wrap.
        do_reset(mk(3'b000, 7'd0, 7'd0, 1'b0, 1'b0));
        for (int i = 0; i < 130; i++) begin
            cycle(mk(3'b000, 7'd0, 7'd0, 1'b0, 1'b0));
            chk("inc_walk_upc", int'(upc), (i + 1) % 128);
        end

        // Timeout abort and single-cycle pulse.
        cycle(mk(3'b001, 7'd9, 7'd0, 1'b0, 1'b0));
        wait_holds(4);
        cycle(mk(3'b100, 7'd10, 7'd0, 1'b0, 1'b0));
        chk("timeout_upc", int'(upc), 127);
        chk("timeout_pulse", int'(mem_timeout), 1);
        cycle(mk(3'b000, 7'd0, 7'd0, 1'b0, 1'b0));
        chk("timeout_pulse_end", int'(mem_timeout), 0);
        chk("after_abort_upc", int'(upc), 0);

        // Stall at the timeout boundary defers the abort.
        cycle(mk(3'b001, 7'd9, 7'd0, 1'b0, 1'b0));
        wait_holds(4);
        for (int k = 0; k < 2; k++) begin
            cycle(mk(3'b100, 7'd10, 7'd0, 1'b0, 1'b1));
            chk("stall_wait_upc", int'(upc), 9);
            chk("stall_wait_pulse", int'(mem_timeout), 0);
        end
        cycle(mk(3'b100, 7'd10, 7'd0, 1'b0, 1'b0));
        chk("stall_release_upc", int'(upc), 127);
        chk("stall_release_pulse", int'(mem_timeout), 1);

        // mfc arriving exactly at the timeout wins.
        cycle(mk(3'b001, 7'd9, 7'd0, 1'b0, 1'b0));
        wait_holds(4);
        cycle(mk(3'b100, 7'd10, 7'd0, 1'b1, 1'b0));
        chk("mfc_wins_upc", int'(upc), 10);
        chk("mfc_wins_pulse", int'(mem_timeout), 0);

        // Reset mid-WAIT abandons the wait and clears the counter.
        cycle(mk(3'b001, 7'd9, 7'd0, 1'b0, 1'b0));
        wait_holds(2);
        do_reset(mk(3'b100, 7'd10, 7'd0, 1'b0, 1'b0));
        cycle(mk(3'b001, 7'd9, 7'd0, 1'b0, 1'b0));
        wait_holds(4);
        cycle(mk(3'b100, 7'd10, 7'd0, 1'b0, 1'b0));
        chk("post_reset_timeout_upc", int'(upc), 127);

        // Nested CALL / RET.
`ifdef USEQ_STACK_EN
        er = '{41, 31, 21, 11, 0};
`else
        er = '{0, 0, 0, 0, 0};
`endif
        do_reset(mk(3'b000, 7'd0, 7'd0, 1'b0, 1'b0));
        cycle(mk(3'b001, 7'd10, 7'd0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            cycle(mk(3'b110, 7'(20 + 10 * i), 7'd0, 1'b0, 1'b0));
            chk("call_upc", int'(upc), 20 + 10 * i);
`ifdef USEQ_STACK_EN
            chk("call_stack_err", int'(stack_err), int'(i == 4));
`else
            chk("call_stack_err", int'(stack_err), 0);
`endif
        end
        for (int i = 0; i < 5; i++) begin
            cycle(mk(3'b111, 7'd99, 7'd0, 1'b0, 1'b0));
            chk("ret_upc", int'(upc), er[i]);
`ifdef USEQ_STACK_EN
            chk("ret_stack_err", int'(stack_err), int'(i == 4));
`else
            chk("ret_stack_err", int'(stack_err), 0);
`endif
        end

        // Randomized traffic against the model.
        do_reset(mk(3'b000, 7'd0, 7'd0, 1'b0, 1'b0));
        for (int i = 0; i < 3000; i++) begin
            x.ns    = 3'($urandom_range(0, 7));
            x.cr    = 7'($urandom);
            x.inv   = 1'($urandom);
            x.cs    = 2'($urandom);
            x.cnd   = 4'($urandom);
            x.disp  = 7'($urandom);
            x.mfc   = ($urandom_range(0, 3) == 0);
            x.stall = ($urandom_range(0, 7) == 0);
            cycle(x);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/useq_ctrl.md
USEQ_CTRL -- requirements
Module: useq_ctrl

Interface
REQ-001 SHALL have parameter FETCH_ADDR, default 7'd0: microaddress of the instruction-fetch routine.
REQ-002 SHALL have parameter ABORT_ADDR, default 7'd127: microaddress entered on a memory timeout.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles in WAIT before abort, range 1-255.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port ns_sel  in  3  next-state field of the current microinstruction.
REQ-007 SHALL have port cr_addr  in  7  target-address field of the current microinstruction.
REQ-008 SHALL have port inv  in  1  condition-invert field.
REQ-009 SHALL have port cond_sel  in  2  selects one bit of cond.
REQ-010 SHALL have port cond  in  4  status conditions (flags or decoder outputs).
REQ-011 SHALL have port dispatch_addr  in  7  entry microaddress from the instruction decoder.
REQ-012 SHALL have port mfc  in  1  memory-function-complete handshake.
REQ-013 SHALL have port stall  in  1  external hold.
REQ-014 SHALL have port upc  out  7  current microaddress; drives the microstore index.
REQ-015 SHALL have port wait_active  out  1  high while the current microinstruction is WAIT.
REQ-016 SHALL have port mem_timeout  out  1  one-cycle pulse on timeout abort.
REQ-017 SHALL have port stack_err  out  1  one-cycle pulse on stack overflow or underflow.

Function
REQ-018 upc SHALL be a register; the microstore is combinational, so fields are valid in the cycle upc is presented and the chosen successor appears after exactly one edge.
REQ-019 Next upc by ns_sel: 000 INC upc+1; 001 JMP cr_addr; 010 DISP dispatch_addr; 011 CBR cr_addr if cond[cond_sel]^inv else upc+1; 100 WAIT; 101 FETCH FETCH_ADDR; 110 CALL; 111 RET.
REQ-020 upc+1 SHALL wrap 127 -> 0 with no flag.
REQ-021 WAIT: mfc=1 -> cr_addr; mfc=0 -> upc held and wait counter increments.
REQ-022 Wait counter (8 bit) SHALL clear on every cycle not in WAIT and on every WAIT exit.
REQ-023 When the counter equals TIMEOUT with mfc=0 in WAIT, next upc SHALL be ABORT_ADDR and mem_timeout SHALL pulse for that edge; mfc=1 in the same cycle wins (no abort).
REQ-024 wait_active SHALL equal (ns_sel==100) combinationally, including while stalled.
REQ-025 stall=1 SHALL freeze upc, wait counter and stack and suppress mem_timeout/stack_err; stall has priority over all other inputs except reset.

Reset
REQ-026 While rst_n=0 at a clock edge: upc=FETCH_ADDR, wait counter=0, stack pointer=0, mem_timeout=0, stack_err=0.
REQ-027 Reset asserted mid-WAIT or mid-subroutine SHALL abandon the operation; no pulse is generated.

Configuration
REQ-028 With USEQ_STACK_EN defined: 4-entry x 7-bit return stack; CALL pushes upc+1 and jumps to cr_addr; RET pops into upc.
REQ-029 With USEQ_STACK_EN: CALL on full SHALL jump without pushing and pulse stack_err; RET on empty SHALL go to FETCH_ADDR and pulse stack_err.
REQ-030 Without USEQ_STACK_EN: CALL behaves as JMP, RET as FETCH, stack_err tied 0, no stack storage.

Structure
REQ-031 Package useq_pkg SHALL hold the ns_sel encodings, UADDR_W=7, and the stack depth constant.
REQ-032 Combinational next-address selection SHALL be sub-module useq_next_addr; useq_ctrl holds upc, counter, stack and pulses.

Verification
REQ-033 Reset, then ns_sel=000 for 130 cycles -> upc 0,1,...,127,0,1.
REQ-034 upc=5, ns_sel=011, cond=4'b0100, cond_sel=2, inv=0, cr_addr=40 -> upc=40; same with inv=1 -> upc=6.
REQ-035 WAIT at upc=9, cr_addr=10, mfc low 3 cycles then high -> upc 9,9,9,9,10; mem_timeout never set.
REQ-036 TIMEOUT=4, WAIT with mfc=0 -> upc held 4 cycles, then upc=127 with mem_timeout high for one cycle.
REQ-037 USEQ_STACK_EN: 5 nested CALLs -> 5th pulses stack_err; 5 RETs -> 4 return upc+1 values LIFO, 5th gives upc=0 and stack_err.
REQ-038 stall=1 for 3 cycles during WAIT with mfc=1 -> upc unchanged; release -> upc=cr_addr next edge.
